vending_change_fsmd: RTL and testbench
======================================

# vending_change_fsmd

Parametrised vending controller FSMD: accepts nickels, dimes and quarters, dispenses one item when the credited balance reaches a configurable price, and returns change one coin at a time over a ready/valid handshake. It also supports customer cancel (full refund) and rejection of illegal or overflowing coins. It is the next-generation replacement for the single-denomination quarter-only controller and sits between the coin acceptor and the dispense/change-hopper drivers.

## Interface
- W, 8: balance accumulator width (bits)
- COST, 125: item price, in cents
- V_NICKEL, 5: nickel value
- V_DIME, 10: dime value
- V_QUARTER, 25: quarter value

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- coin_valid  in  1  coin presented this cycle; sampled only in WAIT
- coin_type  in  2  0 = nickel, 1 = dime, 2 = quarter, 3 = illegal
- cancel  in  1  refund request; sampled only in WAIT
- chg_ready  in  1  hopper accepts the presented change coin
- busy  out  1  high in every state except WAIT; the acceptor holds coins while high
- reject  out  1  one-cycle pulse: the coin was returned uncredited
- dispense  out  1  one-cycle pulse: release the item
- chg_valid  out  1  change coin presented
- chg_type  out  2  change coin type (0, 1 or 2)
- balance  out  W  current credit (registered total)

## Operation
- States: INIT, WAIT, ADD, REJ, DISP, CHANGE. All outputs are Moore, decoded from state and total only.
- INIT: total <= 0; next state WAIT.
- WAIT, evaluated in priority order:
  - coin_valid with a legal type and total + value <= 2^W - 1: coin_reg <= value; next state ADD.
  - coin_valid with type 3, or a legal type that would overflow: next state REJ.
  - total >= COST: next state DISP.
  - cancel and total != 0: next state CHANGE. cancel with total == 0 is ignored.
  - Otherwise remain in WAIT.
- ADD: total <= total + coin_reg; next state WAIT.
- REJ: reject = 1; total unchanged; next state WAIT.
- DISP: dispense = 1; total <= total - COST; next state CHANGE.
- CHANGE, evaluated in priority order:
  - total < V_NICKEL: next state INIT. Any sub-nickel remainder is forfeited.
  - Otherwise chg_valid = 1 and chg_type = the largest coin with value <= total.
  - On chg_valid && chg_ready: total <= total - value; remain in CHANGE.
  - chg_type must not change while chg_valid is high and chg_ready is low.
- busy = (state != WAIT). coin_valid and cancel are ignored outside WAIT.
- Arithmetic is unsigned, W bits. The overflow check uses a W+1-bit sum. total never wraps.
- Reset value of every output is 0 (state = INIT, total = 0). Asserting rst at any point, including mid-CHANGE, abandons the transaction with no refund. The first cycle after rst deasserts is INIT.

## Timing
- A coin accepted in WAIT at cycle t: ADD at t+1; balance updated and state back in WAIT at t+2.
- If that coin completes the price, DISP at t+3 (dispense high) and CHANGE from t+4.
- Each change coin takes 1 cycle when chg_ready is held high. Stalls are unbounded while chg_ready is low.
- From CHANGE with total < V_NICKEL: INIT on the next cycle, then WAIT one cycle later.
- reject is high exactly one cycle, one cycle after the offending coin is presented.

## Test plan
- Defaults, five quarters, chg_ready = 1 -> one dispense pulse, balance 0 after DISP, no chg_valid, returns to WAIT; balance 0.
- Four quarters then three dimes (130) -> dispense; change = one nickel (chg_type 0); balance 0.
- Dime then quarter (35), then cancel -> no dispense; change quarter then dime; WAIT with balance 0.
- coin_type 3 in WAIT -> reject high for one cycle; balance unchanged.
- W = 6 (max 63) with balance 50, quarter offered -> REJ; balance stays 50.
- 150 credited, chg_ready held low 5 cycles -> chg_valid high with chg_type 2 stable; quarter retires only on the ready cycle.
- rst mid-CHANGE -> all outputs 0 immediately; balance 0.

Source files
------------

// File: rtl/vending_change_fsmd.sv
// Multi-denomination vending FSMD: credits nickels/dimes/quarters, dispenses at COST,
// then pays change one coin per chg_valid/chg_ready handshake. Outputs are registered.
module vending_change_fsmd #(
  parameter int W         = 8,
  parameter int COST      = 125,
  parameter int V_NICKEL  = 5,
  parameter int V_DIME    = 10,
  parameter int V_QUARTER = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coin_valid,
  input  logic [1:0]   coin_type,
  input  logic         cancel,
  input  logic         chg_ready,
  output logic         busy,
  output logic         reject,
  output logic         dispense,
  output logic         chg_valid,
  output logic [1:0]   chg_type,
  output logic [W-1:0] balance
);

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_ADD,
    S_REJ,
    S_DISP,
    S_CHANGE
  } state_t;

  localparam logic [W-1:0] VN     = W'(V_NICKEL);
  localparam logic [W-1:0] VD     = W'(V_DIME);
  localparam logic [W-1:0] VQ     = W'(V_QUARTER);
  localparam logic [W-1:0] COST_W = W'(COST);

  state_t       state_q, state_d;
  logic [W-1:0] total_q, total_d;
  logic [W-1:0] coin_q, coin_d;
  logic         busy_q, reject_q, dispense_q, chg_valid_q;
  logic [1:0]   chg_type_q;

  logic [W-1:0] coin_val;
  logic [W:0]   coin_sum;
  logic         coin_legal;
  logic         chg_avail_d;

  function automatic logic [1:0] coin_for(input logic [W-1:0] t);
    if (t >= VQ) return 2'd2;
    if (t >= VD) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [W-1:0] coin_value(input logic [1:0] ct);
    case (ct)
      2'd0:    return VN;
      2'd1:    return VD;
      default: return VQ;
    endcase
  endfunction

  assign coin_legal = (coin_type != 2'd3);
  assign coin_val   = coin_value(coin_type);
  // The extra carry bit flags a coin that would push the total past 2^W-1.
  assign coin_sum   = {1'b0, total_q} + {1'b0, coin_val};

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    coin_d  = coin_q;
    case (state_q)
      S_INIT: begin
        total_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (coin_valid && coin_legal && !coin_sum[W]) begin
          coin_d  = coin_val;
          state_d = S_ADD;
        end else if (coin_valid) begin
          state_d = S_REJ;
        end else if (32'(total_q) >= COST) begin
          state_d = S_DISP;
        end else if (cancel && (total_q != '0)) begin
          state_d = S_CHANGE;
        end
      end
      S_ADD: begin
        total_d = total_q + coin_q;
        state_d = S_WAIT;
      end
      S_REJ: state_d = S_WAIT;
      S_DISP: begin
        total_d = total_q - COST_W;
        state_d = S_CHANGE;
      end
      S_CHANGE: begin
        // A sub-nickel remainder cannot be paid out and is dropped.
        if (total_q < VN) begin
          state_d = S_INIT;
        end else if (chg_ready) begin
          total_d = total_q - coin_value(coin_for(total_q));
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign chg_avail_d = (state_d == S_CHANGE) && (total_d >= VN);

  // Outputs are decoded from the next state/total so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      total_q     <= '0;
      coin_q      <= '0;
      busy_q      <= 1'b0;
      reject_q    <= 1'b0;
      dispense_q  <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_type_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      coin_q      <= coin_d;
      busy_q      <= (state_d != S_WAIT);
      reject_q    <= (state_d == S_REJ);
      dispense_q  <= (state_d == S_DISP);
      chg_valid_q <= chg_avail_d;
      chg_type_q  <= chg_avail_d ? coin_for(total_d) : 2'd0;
    end
  end

  assign busy      = busy_q;
  assign reject    = reject_q;
  assign dispense  = dispense_q;
  assign chg_valid = chg_valid_q;
  assign chg_type  = chg_type_q;
  assign balance   = total_q;

endmodule

// File: tb/tb_vending_change_fsmd.sv
// Directed bench for vending_change_fsmd: default instance plus a W=6 instance for overflow.
module tb_vending_change_fsmd;

  logic       clk;
  logic       rst;
  logic       coin_valid, cancel, chg_ready;
  logic [1:0] coin_type;
  logic       busy, reject, dispense, chg_valid;
  logic [1:0] chg_type;
  logic [7:0] balance;

  logic       c6_valid, c6_cancel, c6_ready;
  logic [1:0] c6_type;
  logic       b6_busy, b6_reject, b6_dispense, b6_chg_valid;
  logic [1:0] b6_chg_type;
  logic [5:0] b6_balance;

  int checks = 0;
  int errors = 0;

  vending_change_fsmd dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .chg_ready(chg_ready), .busy(busy), .reject(reject),
    .dispense(dispense), .chg_valid(chg_valid), .chg_type(chg_type), .balance(balance)
  );

  vending_change_fsmd #(.W(6)) dut6 (
    .clk(clk), .rst(rst), .coin_valid(c6_valid), .coin_type(c6_type),
    .cancel(c6_cancel), .chg_ready(c6_ready), .busy(b6_busy), .reject(b6_reject),
    .dispense(b6_dispense), .chg_valid(b6_chg_valid), .chg_type(b6_chg_type), .balance(b6_balance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, reject, dispense, chg_valid, chg_type, balance}
  function automatic logic [13:0] obs();
    return {busy, reject, dispense, chg_valid, chg_type, balance};
  endfunction

  function automatic logic [11:0] obs6();
    return {b6_busy, b6_reject, b6_dispense, b6_chg_valid, b6_chg_type, b6_balance};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    step();
    coin_valid = 1'b0;
    step();
  endtask

  task automatic coin6(input logic [1:0] t);
    c6_valid = 1'b1;
    c6_type  = t;
    step();
    c6_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; cancel = 1'b0; chg_ready = 1'b1;
    c6_valid = 1'b0; c6_type = 2'd0; c6_cancel = 1'b0; c6_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL reset_outputs got %h exp %h", obs(), 14'h0); end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL reset_to_wait got %h exp %h", obs(), 14'h0); end
  endtask

  task automatic test_five_quarters();
    repeat (4) coin(2'd2);
    checks++;
    if (obs() !== {1'b0,1'b0,1'b0,1'b0,2'd0,8'd100}) begin errors++; $display("FAIL fq_100 got %h exp %h", obs(), {1'b0,1'b0,1'b0,1'b0,2'd0,8'd100}); end
    coin_valid = 1'b1; coin_type = 2'd2;
    step();
    coin_valid = 1'b0;
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b0,2'd0,8'd100}) begin errors++; $display("FAIL fq_add got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b0,2'd0,8'd100}); end
    step();
    checks++;
    if (obs() !== {1'b0,1'b0,1'b0,1'b0,2'd0,8'd125}) begin errors++; $display("FAIL fq_125 got %h exp %h", obs(), {1'b0,1'b0,1'b0,1'b0,2'd0,8'd125}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b1,1'b0,2'd0,8'd125}) begin errors++; $display("FAIL fq_disp got %h exp %h", obs(), {1'b1,1'b0,1'b1,1'b0,2'd0,8'd125}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}) begin errors++; $display("FAIL fq_change got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}) begin errors++; $display("FAIL fq_init got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}); end
    step();
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL fq_wait got %h exp %h", obs(), 14'h0); end
  endtask

  task automatic test_change_nickel();
    repeat (4) coin(2'd2);
    repeat (3) coin(2'd1);
    checks++;
    if (obs() !== {1'b0,1'b0,1'b0,1'b0,2'd0,8'd130}) begin errors++; $display("FAIL cn_130 got %h exp %h", obs(), {1'b0,1'b0,1'b0,1'b0,2'd0,8'd130}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b1,1'b0,2'd0,8'd130}) begin errors++; $display("FAIL cn_disp got %h exp %h", obs(), {1'b1,1'b0,1'b1,1'b0,2'd0,8'd130}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b1,2'd0,8'd5}) begin errors++; $display("FAIL cn_nickel got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b1,2'd0,8'd5}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}) begin errors++; $display("FAIL cn_paid got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}); end
    step();
    step();
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL cn_wait got %h exp %h", obs(), 14'h0); end
  endtask

  task automatic test_cancel();
    coin(2'd1);
    coin(2'd2);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b1,2'd2,8'd35}) begin errors++; $display("FAIL cx_quarter got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b1,2'd2,8'd35}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b1,2'd1,8'd10}) begin errors++; $display("FAIL cx_dime got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b1,2'd1,8'd10}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}) begin errors++; $display("FAIL cx_done got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}); end
    step();
    step();
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL cx_wait got %h exp %h", obs(), 14'h0); end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL cx_zero_ignored got %h exp %h", obs(), 14'h0); end
  endtask

  task automatic test_reject();
    coin(2'd0);
    coin_valid = 1'b1; coin_type = 2'd3;
    step();
    coin_valid = 1'b0;
    checks++;
    if (obs() !== {1'b1,1'b1,1'b0,1'b0,2'd0,8'd5}) begin errors++; $display("FAIL rj_pulse got %h exp %h", obs(), {1'b1,1'b1,1'b0,1'b0,2'd0,8'd5}); end
    step();
    checks++;
    if (obs() !== {1'b0,1'b0,1'b0,1'b0,2'd0,8'd5}) begin errors++; $display("FAIL rj_after got %h exp %h", obs(), {1'b0,1'b0,1'b0,1'b0,2'd0,8'd5}); end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b1,2'd0,8'd5}) begin errors++; $display("FAIL rj_refund got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b1,2'd0,8'd5}); end
    step();
    step();
    step();
  endtask

  task automatic test_overflow_w6();
    coin6(2'd2);
    coin6(2'd2);
    checks++;
    if (obs6() !== {1'b0,1'b0,1'b0,1'b0,2'd0,6'd50}) begin errors++; $display("FAIL ov_50 got %h exp %h", obs6(), {1'b0,1'b0,1'b0,1'b0,2'd0,6'd50}); end
    c6_valid = 1'b1; c6_type = 2'd2;
    step();
    c6_valid = 1'b0;
    checks++;
    if (obs6() !== {1'b1,1'b1,1'b0,1'b0,2'd0,6'd50}) begin errors++; $display("FAIL ov_quarter_rej got %h exp %h", obs6(), {1'b1,1'b1,1'b0,1'b0,2'd0,6'd50}); end
    step();
    coin6(2'd1);
    checks++;
    if (obs6() !== {1'b0,1'b0,1'b0,1'b0,2'd0,6'd60}) begin errors++; $display("FAIL ov_dime_ok got %h exp %h", obs6(), {1'b0,1'b0,1'b0,1'b0,2'd0,6'd60}); end
    c6_valid = 1'b1; c6_type = 2'd0;
    step();
    c6_valid = 1'b0;
    checks++;
    if (obs6() !== {1'b1,1'b1,1'b0,1'b0,2'd0,6'd60}) begin errors++; $display("FAIL ov_nickel_rej got %h exp %h", obs6(), {1'b1,1'b1,1'b0,1'b0,2'd0,6'd60}); end
    step();
  endtask

  task automatic test_stall();
    chg_ready = 1'b0;
    repeat (6) coin(2'd2);
    checks++;
    if (obs() !== {1'b0,1'b0,1'b0,1'b0,2'd0,8'd150}) begin errors++; $display("FAIL st_150 got %h exp %h", obs(), {1'b0,1'b0,1'b0,1'b0,2'd0,8'd150}); end
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b1,1'b0,2'd0,8'd150}) begin errors++; $display("FAIL st_disp got %h exp %h", obs(), {1'b1,1'b0,1'b1,1'b0,2'd0,8'd150}); end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs() !== {1'b1,1'b0,1'b0,1'b1,2'd2,8'd25}) begin errors++; $display("FAIL st_hold%0d got %h exp %h", i, obs(), {1'b1,1'b0,1'b0,1'b1,2'd2,8'd25}); end
      step();
    end
    chg_ready = 1'b1;
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}) begin errors++; $display("FAIL st_retired got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b0,2'd0,8'd0}); end
    step();
    step();
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL st_wait got %h exp %h", obs(), 14'h0); end
  endtask

  task automatic test_rst_mid_change();
    chg_ready = 1'b0;
    repeat (6) coin(2'd2);
    step();
    step();
    checks++;
    if (obs() !== {1'b1,1'b0,1'b0,1'b1,2'd2,8'd25}) begin errors++; $display("FAIL rm_change got %h exp %h", obs(), {1'b1,1'b0,1'b0,1'b1,2'd2,8'd25}); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL rm_async got %h exp %h", obs(), 14'h0); end
    checks++;
    if (obs6() !== 12'h0) begin errors++; $display("FAIL rm_async_w6 got %h exp %h", obs6(), 12'h0); end
    step();
    rst = 1'b0;
    chg_ready = 1'b1;
    step();
    checks++;
    if (obs() !== 14'h0) begin errors++; $display("FAIL rm_wait got %h exp %h", obs(), 14'h0); end
  endtask

  initial begin
    test_reset();
    test_five_quarters();
    test_change_nickel();
    test_cancel();
    test_reject();
    test_overflow_w6();
    test_stall();
    test_rst_mid_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
